// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM encoding,
// port ids, read-latency legal range and the saturating counter helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LOAD = 1'b1;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned CNT_W      = 2;
   localparam int unsigned STAT_W     = 16;

   function automatic logic rd_latency_ok(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the port that was not granted last.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt    = 2'b00;
      gnt_id = PORT_CORE;
      if (valid[0] && (!valid[1] || last == PORT_LOAD)) begin
         gnt[0] = 1'b1;
      end else if (valid[1]) begin
         gnt[1] = 1'b1;
         gnt_id = PORT_LOAD;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory,
// one transaction in flight. Optional counters enabled by MEM_ARB_STATS_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_STATS_EN
   output logic [STAT_W-1:0] stat_gnt0,
   output logic [STAT_W-1:0] stat_gnt1,
   output logic [STAT_W-1:0] stat_conflict,
`endif
   output logic              busy
);

   if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
      $error("mem_port_arbiter: RD_LATENCY must be in 1..4");
   end

   state_t           state;
   logic             last;
   logic             lat_we;
   logic             lat_id;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             accept;

   rr_pick2 u_pick (
      .valid  ({req1_valid, req0_valid}),
      .last   (last),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Ready is only offered in IDLE; held low while reset is asserted.
   assign accept     = (state == IDLE) && (|gnt) && !reset;
   assign req0_ready = accept && gnt[0];
   assign req1_ready = accept && gnt[1];

   // mem_* registers carry the latched address/data and double as the ISSUE strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last       <= PORT_LOAD;
         lat_we     <= 1'b0;
         lat_id     <= PORT_CORE;
         cnt        <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_rdata  <= '0;
         busy       <= 1'b0;
      end else begin
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we    <= (gnt_id == PORT_LOAD) ? req1_we : req0_we;
                  lat_id    <= gnt_id;
                  last      <= gnt_id;
                  mem_en    <= 1'b1;
                  mem_we    <= (gnt_id == PORT_LOAD) ? req1_we : req0_we;
                  mem_addr  <= (gnt_id == PORT_LOAD) ? req1_addr : req0_addr;
                  mem_wdata <= (gnt_id == PORT_LOAD) ? req1_wdata : req0_wdata;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= CNT_W'(RD_LATENCY - 1);
               if (lat_we) begin
                  rsp_rdata  <= '0;
                  rsp0_valid <= (lat_id == PORT_CORE);
                  rsp1_valid <= (lat_id == PORT_LOAD);
                  state      <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_rdata  <= mem_rdata;
                  rsp0_valid <= (lat_id == PORT_CORE);
                  rsp1_valid <= (lat_id == PORT_LOAD);
                  state      <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   // At most one port is ever accepted, so every both-valid cycle is a conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_gnt0     <= '0;
         stat_gnt1     <= '0;
         stat_conflict <= '0;
      end else begin
         if (req0_ready) stat_gnt0 <= sat_inc(stat_gnt0);
         if (req1_ready) stat_gnt1 <= sat_inc(stat_gnt1);
         if (req0_valid && req1_valid) stat_conflict <= sat_inc(stat_conflict);
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random
// two-port traffic checked against a reference memory and timing model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int RDL = 2;

   typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
   typedef struct { int cyc; int port; logic [31:0] rdata; } rsp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  vld;
   logic [1:0]  wev;
   logic [31:0] adr [2];
   logic [31:0] wdt [2];
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_we, busy;
   logic [1:0]  ready_v;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
   int          m_g0, m_g1, m_cf;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(RDL)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(vld[0]), .req0_we(wev[0]), .req0_addr(adr[0]), .req0_wdata(wdt[0]),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .req1_valid(vld[1]), .req1_we(wev[1]), .req1_addr(adr[1]), .req1_wdata(wdt[1]),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
      .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict),
`endif
      .busy(busy)
   );

   assign ready_v = {req1_ready, req0_ready};

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d: got event expected none", name, cyc);
   endtask

   // Memory device: write on mem_en, read data appears RDL cycles later, junk otherwise.
   logic [31:0] dev_mem [32];
   logic [31:0] pipe [4];
   assign mem_rdata = pipe[RDL-1];
   always @(posedge clk) begin
      if (mem_en && mem_we) dev_mem[mem_addr[6:2]] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? dev_mem[mem_addr[6:2]] : $urandom;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
   end

   // Reference model: arbitration order, availability window, memory contents.
   logic [31:0] ref_mem [32];
   cmd_t        cmd_q[$];
   rsp_t        rsp_q[$];
   int          gnt_log[$];
   logic        last_m;
   int          free_at;
   logic [1:0]  prev_v, prev_r;

   always @(negedge clk) begin
      logic [1:0] exp_rdy;
      int         win;
      int         rc;
      cmd_t       c;
      rsp_t       r;
      if (reset) begin
         cmd_q.delete();
         rsp_q.delete();
         last_m  = 1'b1;
         free_at = cyc + 1;
         prev_v  = 2'b00;
         prev_r  = 2'b00;
`ifdef MEM_ARB_STATS_EN
         m_g0 = 0; m_g1 = 0; m_cf = 0;
`endif
         chk("ready_in_reset", {30'd0, ready_v}, 32'd0);
      end else begin
         for (int p = 0; p < 2; p++)
            assert (!(prev_v[p] && !prev_r[p] && !vld[p])) else $error("valid dropped before ready");
         exp_rdy = 2'b00;
         if (cyc >= free_at && vld != 2'b00) begin
            win = (vld == 2'b11) ? int'(!last_m) : int'(vld[1]);
            exp_rdy[win] = 1'b1;
            last_m = win[0];
            c.cyc = cyc + 1; c.we = wev[win]; c.addr = adr[win]; c.wdata = wdt[win];
            cmd_q.push_back(c);
            rc = c.we ? cyc + 2 : cyc + 2 + RDL;
            r.cyc = rc; r.port = win; r.rdata = c.we ? 32'd0 : ref_mem[c.addr[6:2]];
            if (c.we) ref_mem[c.addr[6:2]] = c.wdata;
            rsp_q.push_back(r);
            free_at = rc + 1;
         end
         chk("ready", {30'd0, ready_v}, {30'd0, exp_rdy});
         if (req0_ready) gnt_log.push_back(0);
         if (req1_ready) gnt_log.push_back(1);
`ifdef MEM_ARB_STATS_EN
         if (exp_rdy[0]) m_g0++;
         if (exp_rdy[1]) m_g1++;
         if (vld == 2'b11) m_cf++;
`endif
         prev_v = vld;
         prev_r = ready_v;
      end
   end

   // Monitor: pops the expected memory command / response whenever the DUT presents one.
   always @(negedge clk) begin
      cmd_t c;
      rsp_t r;
      if (!reset) begin
         if (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
            void'(cmd_q.pop_front());
            fail("mem_en_missing");
         end
         if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            void'(rsp_q.pop_front());
            fail("rsp_missing");
         end
         if (mem_en) begin
            if (cmd_q.size() == 0) fail("mem_en_unexpected");
            else begin
               c = cmd_q.pop_front();
               chk("mem_en_cycle", 32'(cyc), 32'(c.cyc));
               chk("mem_we", {31'd0, mem_we}, {31'd0, c.we});
               chk("mem_addr", mem_addr, c.addr);
               chk("mem_wdata", mem_wdata, c.wdata);
            end
         end
         if (rsp0_valid && rsp1_valid) fail("rsp_both_ports");
         else if (rsp0_valid || rsp1_valid) begin
            if (rsp_q.size() == 0) fail("rsp_unexpected");
            else begin
               r = rsp_q.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
               chk("rsp_port", {31'd0, rsp1_valid}, 32'(r.port));
               chk("rsp_rdata", rsp_rdata, r.rdata);
            end
         end
      end
   end

   // Raise a request and hold it until accepted.
   task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
      bit got = 0;
      vld[p] = 1'b1; wev[p] = w; adr[p] = a; wdt[p] = d;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (ready_v[p]) got = 1;
      end
      if (!got) fail("ready_timeout");
      @(posedge clk); #1;
      vld[p] = 1'b0;
   endtask

   task automatic rand_port(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         do_req(p, 1'($urandom), {25'd0, 5'($urandom), 2'b00}, $urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin dev_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      for (int i = 0; i < 4; i++) pipe[i] = 32'd0;
      reset = 1'b1; vld = 2'b00; wev = 2'b00;
      adr[0] = 32'd0; adr[1] = 32'd0; wdt[0] = 32'd0; wdt[1] = 32'd0;
      idle(3);
      reset = 1'b0;

      repeat (5) begin
         @(negedge clk);
         chk("idle_outputs", {26'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, busy}, 32'd0);
         chk("idle_mem", mem_addr | mem_wdata | rsp_rdata | {31'd0, mem_we}, 32'd0);
      end
      @(posedge clk); #1;

      do_req(0, 1'b1, 32'h40, 32'hDEADBEEF);
      idle(3);
      do_req(1, 1'b0, 32'h40, 32'h0);
      idle(5);

      gnt_log.delete();
      fork
         begin do_req(0, 1'b1, 32'h44, 32'h1111_0000); do_req(0, 1'b0, 32'h48, 32'h0); end
         begin do_req(1, 1'b1, 32'h48, 32'h2222_0000); do_req(1, 1'b0, 32'h44, 32'h0); end
      join
      idle(6);
      chk("tie_count", 32'(gnt_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++)
         chk("tie_order", 32'(gnt_log[i]), 32'(i % 2));
`ifdef MEM_ARB_STATS_EN
      chk("stat_gnt0", {16'd0, stat_gnt0}, 32'(m_g0));
      chk("stat_gnt1", {16'd0, stat_gnt1}, 32'(m_g1));
      chk("stat_conflict_nonzero", {31'd0, stat_conflict != 16'd0}, 32'd1);
`endif

      do_req(0, 1'b0, 32'h40, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("busy_after_reset", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      gnt_log.delete();
      fork
         do_req(0, 1'b1, 32'h4C, 32'h3333_0000);
         do_req(1, 1'b1, 32'h50, 32'h4444_0000);
      join
      idle(6);
      chk("tie_after_reset", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF_FFFF, 32'd0);

      fork
         rand_port(0, 5000);
         rand_port(1, 5000);
      join
      idle(10);
      chk("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
      chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
      chk("busy_at_end", {31'd0, busy}, 32'd0);
`ifdef MEM_ARB_STATS_EN
      chk("stat_gnt0_end", {16'd0, stat_gnt0}, 32'(m_g0));
      chk("stat_gnt1_end", {16'd0, stat_gnt1}, 32'(m_g1));
      chk("stat_conflict_end", {16'd0, stat_conflict}, (m_cf > 65535) ? 32'd65535 : 32'(m_cf));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
